// File: rtl/cpu.sv
// Minimal 8-bit accumulator CPU: 6-bit address space, fixed 3-cycle
// fetch/decode/execute sequence against one shared external memory.
module cpu (
   input  logic       clk,
   input  logic       reset,
   output logic [5:0] adr_bus,
   output logic       rd_mem,
   output logic       wr_mem,
   input  logic [7:0] d_in,
   output logic [7:0] d_out
);

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 6;

   localparam logic [1:0] OP_LDA = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_STA = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      DECODE  = 2'b01,
      EXECUTE = 2'b10
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] pc, pc_nxt;
   logic [DW-1:0] ir, ir_nxt;
   logic [DW-1:0] acc, acc_nxt;
   logic [1:0]    op;
   logic [AW-1:0] opnd;

   assign op    = ir[7:6];
   assign opnd  = ir[AW-1:0];
   assign d_out = acc;

   // State and architectural registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         pc    <= '0;
         ir    <= '0;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
         acc   <= acc_nxt;
      end
   end

   // Next-state, register updates and memory strobes
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;
      acc_nxt   = acc;
      adr_bus   = '0;
      rd_mem    = 1'b0;
      wr_mem    = 1'b0;

      case (state)
         FETCH: begin
            adr_bus   = pc;
            rd_mem    = 1'b1;
            ir_nxt    = d_in;
            pc_nxt    = pc + AW'(1);
            state_nxt = DECODE;
         end
         DECODE: begin
            adr_bus   = opnd;
            rd_mem    = (op == OP_LDA) || (op == OP_ADD);
            state_nxt = EXECUTE;
         end
         EXECUTE: begin
            adr_bus   = opnd;
            case (op)
               OP_LDA: begin
                  rd_mem  = 1'b1;
                  acc_nxt = d_in;
               end
               OP_ADD: begin
                  rd_mem  = 1'b1;
                  acc_nxt = DW'(acc + d_in);
               end
               OP_STA: wr_mem = 1'b1;
               OP_JMP: pc_nxt = opnd;
               default: ;
            endcase
            state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase

      // Strobes and address are forced quiet while reset is held so an
      // interrupted store never completes.
      if (!reset) begin
         adr_bus = '0;
         rd_mem  = 1'b0;
         wr_mem  = 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: expected bus observations are queued as
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_cpu;

   logic       clk;
   logic       reset;
   logic [5:0] adr_bus;
   logic       rd_mem;
   logic       wr_mem;
   logic [7:0] d_in;
   logic [7:0] d_out;

   logic [7:0] mem [64];
   logic       use_mem;
   logic [7:0] d_drv;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   passed;

   cpu dut (
      .clk     (clk),
      .reset   (reset),
      .adr_bus (adr_bus),
      .rd_mem  (rd_mem),
      .wr_mem  (wr_mem),
      .d_in    (d_in),
      .d_out   (d_out)
   );

   assign d_in = use_mem ? mem[adr_bus] : d_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void expect_bus(input string tag, input logic [5:0] adr,
                                      input logic rd, input logic wr,
                                      input logic [7:0] d);
      exp_t e;
      e.tag = tag;
      e.val = {adr, rd, wr, d};
      q.push_back(e);
   endfunction

   task automatic check_bus();
      exp_t        e;
      logic [15:0] obs;
      obs = {adr_bus, rd_mem, wr_mem, d_out};
      checks++;
      if (q.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.val) passed++;
         else $error("FAIL %s: observed adr/rd/wr/dout %h required %h", e.tag, obs, e.val);
      end
   endtask

   task automatic check_mem(input string tag, input logic [5:0] a, input logic [7:0] v);
      checks++;
      assert (mem[a] === v) passed++;
      else $error("FAIL %s: observed mem[%0d]=%h required %h", tag, a, mem[a], v);
   endtask

   // One clock; memory model commits a store seen before the edge.
   task automatic cycle();
      logic       we;
      logic [5:0] wa;
      logic [7:0] wd;
      we = wr_mem;
      wa = adr_bus;
      wd = d_out;
      @(posedge clk);
      if (we) mem[wa] = wd;
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic step_check(input string tag, input logic [5:0] adr,
                             input logic rd, input logic wr, input logic [7:0] d);
      cycle();
      expect_bus(tag, adr, rd, wr, d);
      check_bus();
   endtask

   initial begin
      checks  = 0;
      passed  = 0;
      use_mem = 1'b0;
      d_drv   = 8'hA5;
      reset   = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;

      // Reset held with arbitrary data on d_in
      step_check("reset_c1", 6'h00, 1'b0, 1'b0, 8'h00);
      d_drv = 8'h3C;
      step_check("reset_c2", 6'h00, 1'b0, 1'b0, 8'h00);

      // Constant-data stream: 0x05 (LDA 5) then 0x43 (ADD 3)
      reset = 1'b1;
      d_drv = 8'h05;
      #1;
      expect_bus("first_fetch", 6'h00, 1'b1, 1'b0, 8'h00);
      check_bus();
      step_check("lda_decode", 6'h05, 1'b1, 1'b0, 8'h00);
      step_check("lda_exec", 6'h05, 1'b1, 1'b0, 8'h00);
      step_check("lda_result", 6'h01, 1'b1, 1'b0, 8'h05);
      d_drv = 8'h43;
      run(2);
      step_check("add_result", 6'h02, 1'b1, 1'b0, 8'h48);

      // Memory-backed program
      reset = 1'b0;
      #1;
      expect_bus("reset_async", 6'h00, 1'b0, 1'b0, 8'h00);
      check_bus();
      mem[0]  = 8'h0A;   // LDA 10
      mem[1]  = 8'h4B;   // ADD 11
      mem[2]  = 8'h0D;   // LDA 13
      mem[3]  = 8'h8C;   // STA 12
      mem[4]  = 8'hFF;   // JMP 63
      mem[63] = 8'h0E;   // LDA 14
      mem[10] = 8'hF0;
      mem[11] = 8'h20;
      mem[12] = 8'h00;
      mem[13] = 8'h5A;
      mem[14] = 8'h77;
      use_mem = 1'b1;
      cycle();
      reset = 1'b1;
      #1;

      run(3);
      expect_bus("lda_f0", 6'h01, 1'b1, 1'b0, 8'hF0);
      check_bus();
      run(2);
      step_check("add_overflow", 6'h02, 1'b1, 1'b0, 8'h10);
      run(3);
      expect_bus("lda_5a", 6'h03, 1'b1, 1'b0, 8'h5A);
      check_bus();
      step_check("sta_decode", 6'h0C, 1'b0, 1'b0, 8'h5A);
      step_check("sta_exec", 6'h0C, 1'b0, 1'b1, 8'h5A);
      step_check("sta_after", 6'h04, 1'b1, 1'b0, 8'h5A);
      check_mem("sta_mem", 6'd12, 8'h5A);
      step_check("jmp_decode", 6'h3F, 1'b0, 1'b0, 8'h5A);
      step_check("jmp_exec", 6'h3F, 1'b0, 1'b0, 8'h5A);
      step_check("jmp_fetch", 6'h3F, 1'b1, 1'b0, 8'h5A);
      run(2);
      step_check("pc_wrap", 6'h00, 1'b1, 1'b0, 8'h77);

      // Second pass: abort the store with reset during EXECUTE
      mem[12] = 8'h00;
      run(9);
      expect_bus("rerun_sta_fetch", 6'h03, 1'b1, 1'b0, 8'h5A);
      check_bus();
      run(1);
      step_check("rerun_sta_exec", 6'h0C, 1'b0, 1'b1, 8'h5A);
      reset = 1'b0;
      #1;
      expect_bus("mid_reset", 6'h00, 1'b0, 1'b0, 8'h00);
      check_bus();
      cycle();
      check_mem("aborted_store", 6'd12, 8'h00);
      reset = 1'b1;
      #1;
      expect_bus("post_reset_fetch", 6'h00, 1'b1, 1'b0, 8'h00);
      check_bus();
      step_check("post_reset_decode", 6'h0A, 1'b1, 1'b0, 8'h00);

      checks++;
      assert (q.size() == 0) passed++;
      else $error("FAIL scoreboard_drain: observed %0d entries left required 0", q.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
